// File: rtl/lfo_voice_scheduler.sv
// Shares one sine-table BRAM among NUM_VOICES LFO phase accumulators, one read per voice per sample tick.
// Optional LFO_PHASE_SPREAD_EN: voices restart at evenly spread phases instead of all at zero.
module lfo_voice_scheduler #(
    parameter int TABLE_SIZE = 44100,
    parameter int NUM_VOICES = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    enable,
    input  logic                    sample_tick,
    input  logic [16*NUM_VOICES-1:0] voice_step,
    output logic [15:0]             lut_addr,
    output logic                    lut_rd_en,
    input  logic [15:0]             lut_data,
    output logic [16*NUM_VOICES-1:0] lfo_out,
    output logic                    lfo_valid,
    output logic                    busy,
    output logic                    overrun,
    output logic [1:0]              dbg_state
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [15:0] STEP_MAX = 16'(TABLE_SIZE - 1);
    localparam logic [16:0] TABLE_SIZE17 = 17'(TABLE_SIZE);
`ifdef LFO_PHASE_SPREAD_EN
    localparam int SPREAD = 1;
`else
    localparam int SPREAD = 0;
`endif

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DRAIN = 2'd2} state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [15:0]              phase_q [NUM_VOICES];
    logic [15:0]              phase_d [NUM_VOICES];
    logic [15:0]              last_addr_q, last_addr_d;
    logic                     rd_en_dly_q, rd_en_dly_d;
    logic [IDX_W-1:0]         idx_dly_q, idx_dly_d;
    logic [16*NUM_VOICES-1:0] lfo_out_q, lfo_out_d;
    logic                     lfo_valid_q, lfo_valid_d;
    logic                     overrun_q, overrun_d;

    function automatic logic [15:0] reset_phase(input int i);
        return 16'((i * TABLE_SIZE * SPREAD) / NUM_VOICES);
    endfunction

    // Step is clamped below TABLE_SIZE so a single conditional subtract always wraps.
    function automatic logic [15:0] wrap_add(input logic [15:0] phase, input logic [15:0] step);
        logic [15:0] step_c;
        logic [16:0] sum;
        step_c = (step > STEP_MAX) ? STEP_MAX : step;
        sum    = {1'b0, phase} + {1'b0, step_c};
        if (sum >= TABLE_SIZE17) sum = sum - TABLE_SIZE17;
        return sum[15:0];
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (!enable) begin
            state_d = S_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: if (sample_tick) begin
                    state_d = S_ISSUE;
                    idx_d   = '0;
                end
                S_ISSUE: if (idx_q == LAST_IDX) begin
                    state_d = S_DRAIN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
                S_DRAIN: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        lut_rd_en = (state_q == S_ISSUE);
        busy      = (state_q != S_IDLE);
        dbg_state = state_q;
        lut_addr  = lut_rd_en ? phase_q[idx_q] : last_addr_q;
        lfo_out   = lfo_out_q;
        lfo_valid = lfo_valid_q;
        overrun   = overrun_q;
    end

    // A read issued in an aborting cycle is not captured; earlier captures stay in lfo_out.
    always_comb begin
        last_addr_d = lut_addr;
        rd_en_dly_d = lut_rd_en & enable;
        idx_dly_d   = idx_q;
        lfo_out_d   = lfo_out_q;
        if (rd_en_dly_q) lfo_out_d[int'(idx_dly_q)*16 +: 16] = lut_data;
        lfo_valid_d = (state_q == S_DRAIN) & enable;
        overrun_d   = enable ? (overrun_q | (busy & sample_tick)) : 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!enable)                  phase_d[i] = reset_phase(i);
            else if (state_q == S_DRAIN)  phase_d[i] = wrap_add(phase_q[i], voice_step[16*i +: 16]);
            else                          phase_d[i] = phase_q[i];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_addr_q <= '0;
            rd_en_dly_q <= 1'b0;
            idx_dly_q   <= '0;
            lfo_out_q   <= '0;
            lfo_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) phase_q[i] <= reset_phase(i);
        end else begin
            last_addr_q <= last_addr_d;
            rd_en_dly_q <= rd_en_dly_d;
            idx_dly_q   <= idx_dly_d;
            lfo_out_q   <= lfo_out_d;
            lfo_valid_q <= lfo_valid_d;
            overrun_q   <= overrun_d;
            for (int i = 0; i < NUM_VOICES; i++) phase_q[i] <= phase_d[i];
        end
    end

endmodule

// File: tb/tb_lfo_voice_scheduler.sv
// Bench for lfo_voice_scheduler: identity BRAM, sequence-position reference model, per-cycle compare
// plus directed address-sequence checks.
module tb_lfo_voice_scheduler;

    localparam int N  = 4;
    localparam int TS = 44100;
`ifdef LFO_PHASE_SPREAD_EN
    localparam int SP_EN = 1;
`else
    localparam int SP_EN = 0;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          enable = 1'b0;
    logic          sample_tick = 1'b0;
    logic [16*N-1:0] voice_step = '0;
    logic [15:0]   lut_addr;
    logic          lut_rd_en;
    logic [15:0]   lut_data = '0;
    logic [16*N-1:0] lfo_out;
    logic          lfo_valid;
    logic          busy;
    logic          overrun;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int sp_tab [N] = '{0, 11025, 22050, 33075};
    logic [15:0] exp_q[$];
    logic [15:0] addr_log[$];

    lfo_voice_scheduler #(.TABLE_SIZE(TS), .NUM_VOICES(N)) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .sample_tick(sample_tick),
        .voice_step(voice_step), .lut_addr(lut_addr), .lut_rd_en(lut_rd_en),
        .lut_data(lut_data), .lfo_out(lfo_out), .lfo_valid(lfo_valid),
        .busy(busy), .overrun(overrun), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Identity sine table with one-cycle registered read.
    always @(posedge clk) if (lut_rd_en) lut_data <= lut_addr;

    function automatic int sp(input int v);
        return SP_EN ? sp_tab[v] : 0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: position within the tick sequence (0 = idle, 1..N issuing, N+1 draining).
    int m_pos = 0;
    int m_phase [N];
    int m_snap [N];
    int m_out [N];
    int m_last = 0;
    bit m_valid = 0;
    bit m_ovr = 0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_pos = 0; m_last = 0; m_valid = 0; m_ovr = 0;
            for (int v = 0; v < N; v++) begin
                m_phase[v] = sp(v); m_out[v] = 0; m_snap[v] = 0;
            end
        end else begin
            if (m_pos >= 1 && m_pos <= N) m_last = m_snap[m_pos-1];
            if (!enable) begin
                m_pos = 0; m_valid = 0; m_ovr = 0;
                for (int v = 0; v < N; v++) m_phase[v] = sp(v);
            end else begin
                m_valid = (m_pos == N + 1);
                if (m_valid) begin
                    for (int v = 0; v < N; v++) begin
                        int st;
                        st = int'(voice_step[16*v +: 16]);
                        if (st > TS - 1) st = TS - 1;
                        m_out[v]   = m_snap[v];
                        m_phase[v] = (m_phase[v] + st) % TS;
                    end
                end
                if (m_pos != 0) begin
                    if (sample_tick) m_ovr = 1;
                    m_pos = (m_pos == N + 1) ? 0 : m_pos + 1;
                end else if (sample_tick) begin
                    m_pos = 1;
                    for (int v = 0; v < N; v++) m_snap[v] = m_phase[v];
                end
            end
        end
    end

    always @(negedge clk) begin
        bit m_rd;
        int m_addr;
        logic [63:0] m_pack;
        m_rd   = (m_pos >= 1 && m_pos <= N);
        m_addr = m_rd ? m_snap[m_pos-1] : m_last;
        chk("rd_en", 64'(lut_rd_en), 64'(m_rd));
        chk("busy", 64'(busy), 64'(m_pos != 0));
        chk("lfo_valid", 64'(lfo_valid), 64'(m_valid));
        chk("overrun", 64'(overrun), 64'(m_ovr));
        chk("lut_addr", 64'(lut_addr), 64'(m_addr));
        if (m_valid) begin
            m_pack = '0;
            for (int v = 0; v < N; v++) m_pack[16*v +: 16] = 16'(m_out[v]);
            chk("lfo_out", 64'(lfo_out), m_pack);
        end
        if (lfo_valid) valid_cnt++;
        if (lut_rd_en) addr_log.push_back(lut_addr);
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_tick();
        sample_tick = 1'b1;
        cycle();
        sample_tick = 1'b0;
    endtask

    task automatic check_log(input string nm);
        chk({nm, "_len"}, 64'(addr_log.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < addr_log.size(); k++)
            chk(nm, 64'(addr_log[k]), 64'(exp_q[k]));
    endtask

    task automatic reset_phases();
        enable = 1'b0;
        cycle();
        enable = 1'b1;
        cycle();
    endtask

    initial begin
        int v0;
        repeat (3) cycle();
        resetn = 1'b1;
        cycle();
        chk("rst_addr", 64'(lut_addr), 64'd0);
        chk("rst_rd_en", 64'(lut_rd_en), 64'd0);
        chk("rst_lfo_out", 64'(lfo_out), 64'd0);
        chk("rst_valid", 64'(lfo_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);

        // Basic two-tick sequence with small steps and cycle-exact timing.
        enable = 1'b1;
        voice_step = {16'd4, 16'd3, 16'd2, 16'd1};
        cycle();
        addr_log.delete();
        run_tick();
        chk("cyc1_rd_en", 64'(lut_rd_en), 64'd1);
        repeat (4) cycle();
        chk("cyc5_rd_en", 64'(lut_rd_en), 64'd0);
        cycle();
        chk("cyc6_valid", 64'(lfo_valid), 64'd1);
        chk("cyc6_lfo_out", 64'(lfo_out),
            {16'(sp(3)), 16'(sp(2)), 16'(sp(1)), 16'(sp(0))});
        repeat (3) cycle();
        run_tick();
        repeat (8) cycle();
        chk("seq2_lfo_out", 64'(lfo_out),
            {16'(sp(3)+4), 16'(sp(2)+3), 16'(sp(1)+2), 16'(sp(0)+1)});
        exp_q.delete();
        for (int v = 0; v < N; v++) exp_q.push_back(16'(sp(v)));
        for (int v = 0; v < N; v++) exp_q.push_back(16'(sp(v) + v + 1));
        check_log("basic_addr");

        // Wraparound and step clamping on voice 0.
        for (int t = 0; t < 2; t++) begin
            int big;
            logic [15:0] wseq[3];
            big = (t == 0) ? 43000 : 50000;
            wseq[0] = 16'd0;
            wseq[1] = (t == 0) ? 16'd43000 : 16'd44099;
            wseq[2] = (t == 0) ? 16'd41900 : 16'd44098;
            voice_step = {16'd0, 16'd0, 16'd0, 16'(big)};
            reset_phases();
            addr_log.delete();
            exp_q.delete();
            for (int r = 0; r < 3; r++) begin
                run_tick();
                repeat (7) cycle();
                exp_q.push_back(wseq[r]);
                for (int v = 1; v < N; v++) exp_q.push_back(16'(sp(v)));
            end
            check_log((t == 0) ? "wrap_addr" : "clamp_addr");
        end

        // Tick landing exactly on the return-to-idle cycle is accepted.
        voice_step = {16'd40, 16'd30, 16'd20, 16'd10};
        v0 = valid_cnt;
        run_tick();
        repeat (5) cycle();
        run_tick();
        repeat (8) cycle();
        chk("b2b_valids", 64'(valid_cnt - v0), 64'd2);
        chk("b2b_no_overrun", 64'(overrun), 64'd0);

        // Overrun: extra tick in cycle 3 is dropped and flagged.
        v0 = valid_cnt;
        run_tick();
        cycle();
        cycle();
        run_tick();
        chk("ovr_set", 64'(overrun), 64'd1);
        repeat (4) cycle();
        chk("ovr_one_valid", 64'(valid_cnt - v0), 64'd1);
        run_tick();
        repeat (7) cycle();
        chk("ovr_next_valid", 64'(valid_cnt - v0), 64'd2);
        chk("ovr_sticky", 64'(overrun), 64'd1);
        enable = 1'b0;
        cycle();
        enable = 1'b1;
        chk("ovr_cleared", 64'(overrun), 64'd0);
        cycle();

        // Abort by dropping enable in cycle 2.
        voice_step = {16'd400, 16'd300, 16'd200, 16'd100};
        run_tick();
        cycle();
        enable = 1'b0;
        cycle();
        chk("abort_rd_en", 64'(lut_rd_en), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        enable = 1'b1;
        v0 = valid_cnt;
        repeat (8) cycle();
        chk("abort_no_valid", 64'(valid_cnt - v0), 64'd0);
        addr_log.delete();
        run_tick();
        repeat (7) cycle();
        run_tick();
        repeat (7) cycle();
        exp_q.delete();
        for (int v = 0; v < N; v++) exp_q.push_back(16'(sp(v)));
        for (int v = 0; v < N; v++) exp_q.push_back(16'(sp(v) + (v + 1) * 100));
        check_log("abort_addr");

        // Asynchronous reset in the middle of ISSUE.
        run_tick();
        cycle();
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_rd_en", 64'(lut_rd_en), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_lfo_out", 64'(lfo_out), 64'd0);
        repeat (2) cycle();
        resetn = 1'b1;
        cycle();
        addr_log.delete();
        run_tick();
        repeat (7) cycle();
        exp_q.delete();
        for (int v = 0; v < N; v++) exp_q.push_back(16'(sp(v)));
        check_log("arst_addr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfo_voice_scheduler.md
Name: lfo_voice_scheduler

Overview:
- Time-multiplexes one read-only sine-table BRAM among NUM_VOICES chorus-voice LFOs. The BRAM has a 16-bit address, 16-bit data and 1-cycle registered read latency.
- Holds one phase accumulator per voice. On each audio sample tick it issues the voices' reads round-robin, captures the returned sine values, then advances every phase by its per-voice step, modulo TABLE_SIZE.
- Sits between the sample-rate strobe generator and the chorus delay-line modulators.

Parameters:
- TABLE_SIZE, 44100: number of sine-table entries; legal addresses 0..TABLE_SIZE-1.
- NUM_VOICES, 4: number of voices sharing the table (1..8).

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- enable  in  1  scheduler run enable.
- sample_tick  in  1  one-cycle strobe, once per audio sample.
- voice_step  in  16*NUM_VOICES  per-voice phase increment; voice i at bits [16i+15:16i].
- lut_addr  out  16  BRAM read address.
- lut_rd_en  out  1  high on cycles that issue a read.
- lut_data  in  16  BRAM read data, valid the cycle after lut_rd_en.
- lfo_out  out  16*NUM_VOICES  latest sine sample per voice, same packing as voice_step.
- lfo_valid  out  1  one-cycle pulse when all of lfo_out has been refreshed.
- busy  out  1  high while in ISSUE or DRAIN.
- overrun  out  1  sticky flag: a tick arrived while busy.

Behaviour:
- Reset (async, resetn=0): FSM=IDLE, all phases=0, lut_addr=0, lut_rd_en=0, lfo_out=0, lfo_valid=0, busy=0, overrun=0, voice index=0.
- FSM states:
  - IDLE: if enable & sample_tick, go to ISSUE with idx=0.
  - ISSUE: each cycle drive lut_addr=phase[idx], lut_rd_en=1, then idx++. After idx=NUM_VOICES-1 is issued, go to DRAIN.
  - DRAIN: one cycle to capture the final read, then return to IDLE.
- Capture: a one-cycle-delayed copy of idx and rd_en selects the destination; lut_data is registered into lfo_out[idx_d] on the edge after the rd_en cycle.
- Cycle timing (tick sampled in cycle 0):
  - lut_rd_en high in cycles 1..N.
  - Last data captured at end of cycle N+1.
  - lfo_valid=1 and all lfo_out stable in cycle N+2; FSM is back in IDLE in that cycle.
  - Minimum tick spacing is N+2 cycles.
- lut_addr holds its last value when lut_rd_en=0. lfo_out voices update individually during the sequence; consumers sample only on lfo_valid.
- Phase update: on the DRAIN->IDLE edge, every phase[i] <= wrap(phase[i] + step_c[i]).
  - step_c = min(voice_step[i], TABLE_SIZE-1).
  - The sum is computed at 17 bits; if sum >= TABLE_SIZE, subtract TABLE_SIZE. The result is always < TABLE_SIZE.
  - voice_step is sampled at that edge only.
- Overrun: sample_tick=1 while busy sets overrun=1 and the tick is dropped; the running sequence is unaffected. overrun clears only on reset or enable=0.
- A tick in the same cycle the FSM returns to IDLE (cycle N+2) is accepted normally.
- enable=0:
  - In IDLE: phases forced to 0 (or the spread values below), overrun cleared.
  - Mid-sequence: abort. Next cycle is IDLE with lut_rd_en=0, no lfo_valid, no phase advance, phases reset.
  - Already-captured lfo_out values are kept.
- Ticks with enable=0 are ignored and do not set overrun.
- Async reset mid-sequence: all outputs go to reset values immediately, with no clock edge required.

Optional Feature:
- Macro: LFO_PHASE_SPREAD_EN.
- Defined: the phase reset value for voice i (on reset and whenever enable=0) is (i*TABLE_SIZE)/NUM_VOICES, integer floor, computed at elaboration. This gives evenly spread voices, e.g. 0, 11025, 22050, 33075 for N=4.
- Undefined: all voices reset to phase 0.

Test Plan:
All scenarios use N=4, TABLE_SIZE=44100, and a bench BRAM model with an identity table (data=addr).
- Reset, enable=1, steps {1,2,3,4}, tick at cycle 0 -> lut_addr 0,0,0,0 on cycles 1-4; lfo_valid in cycle 6; lfo_out all 0. Second tick -> addresses 1,2,3,4; lfo_out={1,2,3,4}.
- Voice0 step 43000, three ticks -> voice0 read addresses 0, 43000, 41900 (wrap).
- Voice0 step 50000 -> clamped to 44099; addresses 0, 44099, 44098.
- Tick repeated in cycle 3 of a sequence -> overrun=1; exactly one lfo_valid; a following legal tick runs normally; enable=0 clears overrun.
- enable dropped in cycle 2 -> lut_rd_en=0 from cycle 3; no lfo_valid; re-enable plus tick -> addresses 0,0,0,0 (spread build: 0,11025,22050,33075).
- resetn asserted mid-ISSUE -> lut_rd_en, busy and lfo_out go to 0 immediately without a clock edge; after release, the first tick reads from phase 0.
